// File: rtl/dp_hazard_pipe.sv
// dp_hazard_pipe
//   Control-side sequencer for a five-stage IF/ID/EX/M/WB data path. It carries
//   the control bundle of each instruction from ID through WB with per-stage
//   valid bits. It detects load-use hazards (stall plus EX bubble) and taken
//   branches resolved in M (IF/ID flush plus EX/M bubbles). It computes the EX
//   operand forwarding selects and keeps saturating stall/flush event counters.
// Ports:
//   clk, rst                      rising-edge clock, async active-high reset
//   id_*                          decoded fields of the instruction sitting in ID
//   m_branch_en                   branch taken, resolved in M
//   pc_hold/ifid_hold/ifid_flush  front-end control (combinational)
//   ex/m/wb_valid, *_ctrl, *_rd   per-stage pipeline state
//   wb_reg_load                   register-file write enable, gated by wb_valid
//   fwd_a_sel/fwd_b_sel           0 = regfile, 1 = EX/M ALU result, 2 = WB data
//   stall_cnt/flush_cnt           saturating event counters
module dp_hazard_pipe #(
  parameter int RA_W     = 3,
  parameter int CTRL_W   = 16,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_reg_load,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              m_branch_en,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              ex_valid,
  output logic              m_valid,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] m_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [RA_W-1:0]   m_rd,
  output logic [RA_W-1:0]   wb_rd,
  output logic              wb_reg_load,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // An address takes part in hazards/forwarding unless it is a hardwired r0.
  function automatic logic reg_live(input logic [RA_W-1:0] addr);
    return (ZERO_REG == 0) || (addr != {RA_W{1'b0}});
  endfunction

  function automatic logic src_match(input logic used, input logic [RA_W-1:0] src,
                                     input logic prod_valid, input logic prod_load,
                                     input logic [RA_W-1:0] prod_rd);
    return used && (src == prod_rd) && reg_live(src) && prod_valid && prod_load;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  logic              ex_valid_q, ex_valid_d, m_valid_q, m_valid_d, wb_valid_q, wb_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d, m_ctrl_q, m_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [RA_W-1:0]   ex_rd_q, ex_rd_d, m_rd_q, m_rd_d, wb_rd_q, wb_rd_d;
  logic              ex_reg_load_q, ex_reg_load_d, m_reg_load_q, m_reg_load_d;
  logic              wb_reg_load_q, wb_reg_load_d;
  logic              ex_mem_read_q, ex_mem_read_d, m_mem_read_q, m_mem_read_d;
  logic [RA_W-1:0]   ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic              ex_rs1_used_q, ex_rs1_used_d, ex_rs2_used_q, ex_rs2_used_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              branch, stall, ex_load_hit, m_load_hit;

  // Hazard detection: branch flush wins over a load-use stall.
  always_comb begin
    branch      = m_branch_en && m_valid_q;
    ex_load_hit = ex_mem_read_q &&
                  (src_match(id_rs1_used, id_rs1, ex_valid_q, ex_reg_load_q, ex_rd_q) ||
                   src_match(id_rs2_used, id_rs2, ex_valid_q, ex_reg_load_q, ex_rd_q));
    m_load_hit  = m_mem_read_q &&
                  (src_match(id_rs1_used, id_rs1, m_valid_q, m_reg_load_q, m_rd_q) ||
                   src_match(id_rs2_used, id_rs2, m_valid_q, m_reg_load_q, m_rd_q));
    stall       = id_valid && !branch && (ex_load_hit || m_load_hit);
    pc_hold     = stall;
    ifid_hold   = stall;
    ifid_flush  = branch;
  end

  // Next pipeline state: bubble EX on stall/flush, bubble M on flush, WB always advances.
  always_comb begin
    if (stall || branch) begin
      ex_valid_d    = 1'b0;
      ex_ctrl_d     = {CTRL_W{1'b0}};
      ex_rd_d       = {RA_W{1'b0}};
      ex_reg_load_d = 1'b0;
      ex_mem_read_d = 1'b0;
      ex_rs1_d      = {RA_W{1'b0}};
      ex_rs2_d      = {RA_W{1'b0}};
      ex_rs1_used_d = 1'b0;
      ex_rs2_used_d = 1'b0;
    end else begin
      ex_valid_d    = id_valid;
      ex_ctrl_d     = id_ctrl;
      ex_rd_d       = id_rd;
      ex_reg_load_d = id_reg_load;
      ex_mem_read_d = id_mem_read;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rs1_used_d = id_rs1_used;
      ex_rs2_used_d = id_rs2_used;
    end
    if (branch) begin
      m_valid_d    = 1'b0;
      m_ctrl_d     = {CTRL_W{1'b0}};
      m_rd_d       = {RA_W{1'b0}};
      m_reg_load_d = 1'b0;
      m_mem_read_d = 1'b0;
    end else begin
      m_valid_d    = ex_valid_q;
      m_ctrl_d     = ex_ctrl_q;
      m_rd_d       = ex_rd_q;
      m_reg_load_d = ex_reg_load_q;
      m_mem_read_d = ex_mem_read_q;
    end
    wb_valid_d    = m_valid_q;
    wb_ctrl_d     = m_ctrl_q;
    wb_rd_d       = m_rd_q;
    wb_reg_load_d = m_reg_load_q;
    stall_cnt_d   = stall  ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d   = branch ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  // Forwarding selects; a load in M has no ALU result yet, so only non-loads forward from M.
  always_comb begin
    if (ex_valid_q && src_match(ex_rs1_used_q, ex_rs1_q, m_valid_q,
                                m_reg_load_q && !m_mem_read_q, m_rd_q)) begin
      fwd_a_sel = 2'd1;
    end else if (ex_valid_q && src_match(ex_rs1_used_q, ex_rs1_q, wb_valid_q,
                                         wb_reg_load_q, wb_rd_q)) begin
      fwd_a_sel = 2'd2;
    end else begin
      fwd_a_sel = 2'd0;
    end
    if (ex_valid_q && src_match(ex_rs2_used_q, ex_rs2_q, m_valid_q,
                                m_reg_load_q && !m_mem_read_q, m_rd_q)) begin
      fwd_b_sel = 2'd1;
    end else if (ex_valid_q && src_match(ex_rs2_used_q, ex_rs2_q, wb_valid_q,
                                         wb_reg_load_q, wb_rd_q)) begin
      fwd_b_sel = 2'd2;
    end else begin
      fwd_b_sel = 2'd0;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= {CTRL_W{1'b0}};
      ex_rd_q       <= {RA_W{1'b0}};
      ex_reg_load_q <= 1'b0;
      ex_mem_read_q <= 1'b0;
      ex_rs1_q      <= {RA_W{1'b0}};
      ex_rs2_q      <= {RA_W{1'b0}};
      ex_rs1_used_q <= 1'b0;
      ex_rs2_used_q <= 1'b0;
      m_valid_q     <= 1'b0;
      m_ctrl_q      <= {CTRL_W{1'b0}};
      m_rd_q        <= {RA_W{1'b0}};
      m_reg_load_q  <= 1'b0;
      m_mem_read_q  <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_ctrl_q     <= {CTRL_W{1'b0}};
      wb_rd_q       <= {RA_W{1'b0}};
      wb_reg_load_q <= 1'b0;
      stall_cnt_q   <= {CNT_W{1'b0}};
      flush_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rd_q       <= ex_rd_d;
      ex_reg_load_q <= ex_reg_load_d;
      ex_mem_read_q <= ex_mem_read_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rs1_used_q <= ex_rs1_used_d;
      ex_rs2_used_q <= ex_rs2_used_d;
      m_valid_q     <= m_valid_d;
      m_ctrl_q      <= m_ctrl_d;
      m_rd_q        <= m_rd_d;
      m_reg_load_q  <= m_reg_load_d;
      m_mem_read_q  <= m_mem_read_d;
      wb_valid_q    <= wb_valid_d;
      wb_ctrl_q     <= wb_ctrl_d;
      wb_rd_q       <= wb_rd_d;
      wb_reg_load_q <= wb_reg_load_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign m_valid     = m_valid_q;
  assign wb_valid    = wb_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign m_ctrl      = m_ctrl_q;
  assign wb_ctrl     = wb_ctrl_q;
  assign m_rd        = m_rd_q;
  assign wb_rd       = wb_rd_q;
  assign wb_reg_load = wb_reg_load_q && wb_valid_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
